// File: rtl/clkdiv_cfg_seq_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_cfg_seq_pkg
// Shared chip-core clocking definitions used by the divider configuration
// sequencer and anything else that talks to the output clock divider.
//   DIV_W        : width of a divider ratio
//   DIV_BYPASS   : ratio value that puts the divider into bypass
//   seq_state_t  : sequencer state encoding (2-bit)
//   norm_div     : maps a requested ratio of 0 onto bypass (1)
//   norm_step    : maps a ramp step of 0 onto 1
// ---------------------------------------------------------------------------
package clkdiv_cfg_seq_pkg;

    localparam int DIV_W = 16;
    localparam logic [DIV_W-1:0] DIV_BYPASS = 16'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_A = 2'd1,
        SET_B = 2'd2,
        RAMP  = 2'd3
    } seq_state_t;

    // A ratio of 0 has no meaning to the divider, so it is treated as bypass.
    function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_BYPASS : d;
    endfunction

    // A zero step would stall a ramp forever, so the smallest step is 1.
    function automatic logic [7:0] norm_step(input logic [7:0] s);
        return (s == 8'd0) ? 8'd1 : s;
    endfunction

endpackage

// File: rtl/clkdiv_cfg_seq_if.sv
// ---------------------------------------------------------------------------
// clkdiv_cfg_seq_if
// Bundle between the register block / divider and the configuration
// sequencer.
//   cfg_valid, cfg_div, cfg_ramp, cfg_step : ratio request (master -> slave)
//   cfg_ready                              : request accept (slave -> master)
//   abort                                  : cancel sequence (master -> slave)
//   div_out                                : divider ratio (slave -> divider)
//   busy, done                             : status (slave -> master)
// The sequencer uses the slave modport; the register block side (or a
// testbench) uses the master modport.
// ---------------------------------------------------------------------------
interface clkdiv_cfg_seq_if;
    import clkdiv_cfg_seq_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ramp;
    logic [7:0]       cfg_step;
    logic             abort;
    logic [DIV_W-1:0] div_out;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_ramp,
        output cfg_step,
        output abort,
        input  cfg_ready,
        input  div_out,
        input  busy,
        input  done
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_ramp,
        input  cfg_step,
        input  abort,
        output cfg_ready,
        output div_out,
        output busy,
        output done
    );

endinterface

// File: rtl/clkdiv_cfg_tmr.sv
// ---------------------------------------------------------------------------
// clkdiv_cfg_tmr
// Loadable down-counter that times settle windows and ramp dwell periods.
//   clk, rst  : clock and synchronous active-high reset
//   clear     : drop any running count (abort / state exit)
//   load      : start a new count of load_val+1 cycles
//   load_val  : value loaded into the counter
//   running   : a count is in progress (including its expiry cycle)
//   expire    : one-cycle strobe in the last cycle of a count
// A load of N makes expire high during the N+1-th cycle after the load edge,
// so the owner acts on the expiry at exactly N+1 edges after loading.
// ---------------------------------------------------------------------------
module clkdiv_cfg_tmr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             running,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    // Counter state: clear beats load, load beats counting. Once the count
    // reaches zero the timer disarms itself unless reloaded on that same edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign running = armed;
    assign expire  = armed && (cnt == '0);

endmodule

// File: rtl/clkdiv_cfg_seq.sv
// ---------------------------------------------------------------------------
// clkdiv_cfg_seq
// Configuration sequencer in front of the output clock divider. Accepts
// ratio requests and changes div_out either through a bypass/settle
// sequence (direct) or in dwell-spaced steps (ramp), so the divided clock
// never jumps abruptly.
//   SETTLE_CYC : cycles in each settle window (>= 2)
//   DWELL_CYC  : cycles each intermediate ramp ratio is held (>= 1)
//   clk, rst   : clock and synchronous active-high reset
//   bus        : slave side of clkdiv_cfg_seq_if (request, abort, div_out,
//                busy/done status)
// ---------------------------------------------------------------------------
module clkdiv_cfg_seq
    import clkdiv_cfg_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int DWELL_CYC  = 16
) (
    input  logic            clk,
    input  logic            rst,
    clkdiv_cfg_seq_if.slave bus
);

    localparam int TMR_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
    localparam int CNT_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam int XW      = DIV_W + 1;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] tgt;
    logic [DIV_W-1:0] tgt_nxt;
    logic [7:0]       step;
    logic [7:0]       step_nxt;
    logic             done_q;
    logic             done_nxt;
    logic             eq_pend;
    logic             eq_pend_nxt;

    logic             tmr_clear;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_running;
    logic             tmr_expire;

    logic [DIV_W-1:0] req_tgt;
    logic [XW-1:0]    cur_x;
    logic [XW-1:0]    tgt_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    gap;
    logic [XW-1:0]    mag;
    logic [XW-1:0]    ramp_x;
    logic             ramp_up;
    logic             ramp_hit;

    clkdiv_cfg_tmr #(
        .CNT_W (CNT_W)
    ) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .running  (tmr_running),
        .expire   (tmr_expire)
    );

    assign req_tgt = norm_div(bus.cfg_div);

    // Ramp step arithmetic. Everything is one bit wider than a ratio so a
    // step above 0xFFFF cannot wrap; the step is limited to the remaining
    // gap, which makes the last update land exactly on the target.
    always_comb begin
        cur_x   = {1'b0, div_q};
        tgt_x   = {1'b0, tgt};
        step_x  = XW'(step);
        ramp_up = (tgt_x > cur_x);
        gap     = ramp_up ? (tgt_x - cur_x) : (cur_x - tgt_x);
        mag     = (step_x < gap) ? step_x : gap;
        ramp_x  = ramp_up ? (cur_x + mag) : (cur_x - mag);
        ramp_hit = (ramp_x == tgt_x);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decisions. Abort from any busy state wins over
    // everything else. SET_A starts its settle timer on its first cycle
    // rather than at acceptance, which gives the divider one extra bypass
    // cycle before the settle window is counted.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_q;
        tgt_nxt     = tgt;
        step_nxt    = step;
        done_nxt    = 1'b0;
        eq_pend_nxt = 1'b0;
        tmr_clear   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = SETTLE_LD;

        if (bus.abort && (state != IDLE)) begin
            state_nxt = IDLE;
            div_nxt   = DIV_BYPASS;
            tmr_clear = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    done_nxt = eq_pend;
                    if (bus.abort) begin
                        div_nxt = DIV_BYPASS;
                    end else if (bus.cfg_valid) begin
                        tgt_nxt  = req_tgt;
                        step_nxt = norm_step(bus.cfg_step);
                        if (req_tgt == div_q) begin
                            eq_pend_nxt = 1'b1;
                        end else if (!bus.cfg_ramp || (div_q <= DIV_BYPASS) ||
                                     (req_tgt <= DIV_BYPASS)) begin
                            state_nxt = SET_A;
                            div_nxt   = DIV_BYPASS;
                        end else begin
                            state_nxt = RAMP;
                            tmr_load  = 1'b1;
                            tmr_val   = DWELL_LD;
                        end
                    end
                end
                SET_A: begin
                    div_nxt = DIV_BYPASS;
                    if (tmr_expire) begin
                        state_nxt = SET_B;
                        div_nxt   = tgt;
                        tmr_load  = 1'b1;
                        tmr_val   = SETTLE_LD;
                    end else if (!tmr_running) begin
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LD;
                    end
                end
                SET_B: begin
                    if (tmr_expire) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                RAMP: begin
                    if (tmr_expire) begin
                        div_nxt = ramp_x[DIV_W-1:0];
                        if (ramp_hit) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            tmr_load = 1'b1;
                            tmr_val  = DWELL_LD;
                        end
                    end
                end
            endcase
        end
    end

    // Registered outputs and request capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= DIV_BYPASS;
            tgt     <= DIV_BYPASS;
            step    <= 8'd1;
            done_q  <= 1'b0;
            eq_pend <= 1'b0;
        end else begin
            div_q   <= div_nxt;
            tgt     <= tgt_nxt;
            step    <= step_nxt;
            done_q  <= done_nxt;
            eq_pend <= eq_pend_nxt;
        end
    end

    assign bus.div_out   = div_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE);
    assign bus.cfg_ready = (state == IDLE) && !bus.abort;

endmodule

// File: doc/clkdiv_cfg_seq.md
# clkdiv_cfg_seq

Configuration sequencer directly upstream of the chip's output clock divider. It accepts divider-ratio requests from the register block over a valid/ready handshake and drives the divider's 16-bit `div` input. Ratio changes are sequenced so the off-chip divided clock never sees an abrupt jump:
- **Direct mode:** pass through bypass with settle windows.
- **Ramp mode:** step gradually toward the target.

It also reports busy and done status back to the register block.

## Interface
- `SETTLE_CYC`, default 4 — cycles held in each settle window (≥2).
- `DWELL_CYC`, default 16 — cycles each intermediate ratio is held in ramp mode (≥1).
- `clk` input 1 — single clock. Also clocks the downstream divider.
- `rst` input 1 — reset. Synchronous and active-high; the only reset.
- `cfg_valid` input 1 — request valid.
- `cfg_ready` output 1 — request accepted when `cfg_valid && cfg_ready` at a rising edge.
- `cfg_div` input 16 — target ratio. 0 is normalised to 1 at acceptance.
- `cfg_ramp` input 1 — 1 selects ramp mode, 0 selects direct mode.
- `cfg_step` input 8 — ramp increment. 0 is treated as 1.
- `abort` input 1 — cancels any sequence in progress.
- `div_out` output 16 — drives the divider `div` input. A value ≤1 means bypass.
- `busy` output 1 — sequence in progress.
- `done` output 1 — one-cycle pulse when a sequence completes normally.

## Operation
- **Reset values:** `div_out`=1, `busy`=0, `done`=0, `cfg_ready`=1, state IDLE.
- **States:** IDLE, SET_A, SET_B, RAMP.
- `cfg_ready` = (state==IDLE) and not `abort`.
- Target `tgt` is latched at acceptance, with 0 replaced by 1.
- **Acceptance, target equal to current `div_out`:** no state change. `done` pulses the next cycle.
- **Acceptance, direct mode:** go to SET_A.
  - Also taken in ramp mode when the current `div_out` ≤1 or `tgt` ≤1. Ramping never crosses the bypass boundary.
- **Acceptance, ramp mode:** go to RAMP otherwise.
- **SET_A:**
  - `div_out`=1 (forces divider bypass and resets its counter).
  - After SETTLE_CYC cycles: `div_out`←`tgt`, go to SET_B.
- **SET_B:**
  - `div_out` holds `tgt`.
  - After SETTLE_CYC cycles: pulse `done`, go to IDLE.
- **RAMP:**
  - Every DWELL_CYC cycles, `div_out` moves toward `tgt` by min(step, |tgt−div_out|). The final step clamps exactly to `tgt`, with no overshoot.
  - Arithmetic is 17-bit internally, so 0xFFFF plus step cannot wrap.
  - When `div_out`==`tgt` after an update, pulse `done` and go to IDLE in the same cycle as that update.
- `busy`=1 in SET_A, SET_B and RAMP.
- **`abort`, any busy state:**
  - Next cycle: `div_out`=1, state IDLE, `busy`=0.
  - No `done` pulse. The dwell/settle counter is cleared.
- **`abort` in IDLE:** forces `div_out`=1. `cfg_ready` is low in that cycle.
- **`rst` asserted mid-sequence:** all outputs return to reset values on the next edge.
- **Requests while busy:** held off by `cfg_ready`=0. The requester keeps `cfg_valid` high and there is no queueing.

## Timing
- Acceptance edge = T.
- **Direct mode:**
  - `div_out`=1 during cycles T+1 … T+SETTLE_CYC.
  - `div_out`=`tgt` from T+SETTLE_CYC+1.
  - `done`=1 and `busy`=0 at T+2·SETTLE_CYC+1.
  - `cfg_ready` is high from T+2·SETTLE_CYC+1.
- **Ramp mode:**
  - First update at T+DWELL_CYC. The k-th update is at T+k·DWELL_CYC.
  - `done` coincides with the final update.
- **Equal-target request:** `done` at T+1. `busy` stays 0.
- The downstream divider needs ≥2 cycles of `div`≤1 to see its enable drop through its pipeline. SETTLE_CYC≥2 therefore guarantees a clean bypass.
- All outputs are registered. There is no combinational path from `cfg_*` to `div_out`.

## Structure
- A shared chip-core clocking package holds:
  - the state encoding (2-bit enum);
  - the constant `DIV_BYPASS`=16'd1;
  - the width constant `DIV_W`=16.
- One sub-module, `clkdiv_cfg_tmr`:
  - loadable down-counter producing a one-cycle expiry strobe;
  - loaded with SETTLE_CYC−1 or DWELL_CYC−1;
  - clearable by `abort`/state exit.
- The top module holds the FSM, the target/step registers, and the step/clamp arithmetic.

## Test plan
- **Reset then direct request:** `rst` high 2 cycles, then `cfg_div`=10, `cfg_ramp`=0 → `div_out` 1 for 4 cycles, then 10; `done` at T+9; `busy` low after.
- **Ramp up:** from `div_out`=4, request 10, step 4, ramp=1, DWELL_CYC=16 → `div_out` 8 at T+16, 10 at T+32 (clamped), `done` at T+32.
- **Ramp down to 0:** from 6, request 0, ramp=1 → normalised to 1, falls back to direct; `div_out` 1 through T+SETTLE_CYC, then 1 held; `done` at T+9.
- **Abort:** `abort` mid-ramp from 100 toward 200 at `div_out`=150 → next cycle `div_out`=1, `busy`=0, no `done`, `cfg_ready`=1 the following cycle.
- **Back-pressure:** `cfg_valid` held with `cfg_div`=50 during a busy sequence → `cfg_ready` low until completion; accepted at the first IDLE cycle, and the second sequence runs to 50.
- **Equal target:** request equal to current 0x0020 → `done` at T+1, `div_out` unchanged. Repeat with 0xFFFF, step 255, from 0xFF80 → single clamp to 0xFFFF, no wrap.
